beam_sweep_controller: RTL and testbench
========================================

Name: beam_sweep_controller

Overview:
Steering controller for the delay-and-sum beamformer. It drives the per-mic delay inputs (delay_1..delay_4) of the delay/sum datapath and can run an automatic sweep. In a sweep it steps through NUM_ANGLES steering angles, discards settling samples after each delay change, and accumulates |beamformed output| over a dwell window. It then locks the delays to the angle with maximum energy. In manual mode it applies a user-selected angle.

Parameters:
NUM_MICS, 4, active mics (2..4); delay outputs for mics above NUM_MICS are held at 0
BITS_AUDIO, 24, width of beamformed sample
NUM_ANGLES, 16, steering positions (power of 2, >=2); AW = $clog2(NUM_ANGLES)
DELAY_STEP, 2, delay units per mic per angle step
SETTLE_SAMPLES, 8, valid samples discarded after each angle change (covers datapath latency)
DWELL_SAMPLES, 256, valid samples accumulated per angle (power of 2)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
start_in  in  1  single-cycle pulse; starts sweep when idle
manual_en_in  in  1  when idle, apply manual_angle_in
manual_angle_in  in  AW  manual steering index
audio_in  in  BITS_AUDIO signed  beamformed sample from delay/sum datapath
audio_valid_in  in  1  audio_in valid
delay_1..delay_4  out  8 each  per-mic delays to datapath, registered
angle_out  out  AW  angle currently applied
best_angle_out  out  AW  winning angle of last sweep
best_energy_out  out  BITS_AUDIO+$clog2(DWELL_SAMPLES) unsigned  winning energy
busy_out  out  1  sweep in progress
sweep_done_out  out  1  one-cycle pulse at sweep end

Behaviour:
- One clock domain (clk_in). Reset is synchronous, active-high.
- Steering law: s = angle - NUM_ANGLES/2 (signed).
  - Mic k (0-based) delay = k*s*DELAY_STEP if s>=0, else (NUM_MICS-1-k)*(-s)*DELAY_STEP.
  - Saturate each delay at 255.
- delay_* are registered from angle_out and change exactly 1 cycle after angle_out changes.
- Reset values:
  - Internal angle register and angle_out = NUM_ANGLES/2 (broadside); all delay_* = 0.
  - best_angle_out = NUM_ANGLES/2; best_energy_out = 0.
  - busy_out = 0; sweep_done_out = 0; state IDLE.
- Energy: acc += |audio_in|, with |x| computed as an unsigned BITS_AUDIO value, so |-2^(B-1)| = 2^(B-1). Acc width cannot overflow.
- FSM:
  - IDLE:
    - start_in: angle=0, best_energy=0, best_angle=NUM_ANGLES/2, cnt=0, busy=1 -> SETTLE.
    - Else if manual_en_in: angle=manual_angle_in. start_in has priority when both are asserted.
  - SETTLE: count audio_valid_in. On the SETTLE_SAMPLES-th valid: cnt=0, acc=0 -> MEASURE.
  - MEASURE: each valid sample accumulates and increments cnt. The DWELL_SAMPLES-th valid sample is included, then -> COMPARE.
  - COMPARE (1 cycle):
    - If acc > best_energy (strict; ties keep the earlier angle): best_energy=acc, best_angle=angle.
    - If angle==NUM_ANGLES-1 -> DONE; else angle++, cnt=0 -> SETTLE.
  - DONE (1 cycle): angle=best_angle, sweep_done_out=1, busy=0 -> IDLE.
- While busy: start_in and manual_en_in are ignored; best_* outputs update in COMPARE.
- audio_valid_in gaps simply stall counting; there is no timeout.
- rst_in mid-sweep returns everything to reset values next cycle, with no done pulse.

Test Plan:
Use NUM_ANGLES=16, DWELL_SAMPLES=4, SETTLE_SAMPLES=2, DELAY_STEP=2, NUM_MICS=4.
1. Reset held 2 cycles -> delay_1..4=0, angle_out=8, best_angle_out=8, best_energy_out=0, busy_out=0.
2. Manual mode:
   - manual_en_in=1, manual_angle_in=11 -> angle_out=11, then next cycle delays=0,6,12,18.
   - manual_angle_in=5 -> delays=18,12,6,0.
   - manual_angle_in=0 -> delays=48,32,16,0.
3. Sweep, audio_valid_in every 4th cycle, |audio_in|=100 when angle_out==3 else 10 -> sweep_done_out pulses once after 96 valid samples.
   - Expect best_angle_out=3, best_energy_out=400, angle_out=3, delays=30,20,10,0, busy_out=0.
4. Sweep with constant audio_in=50 on all angles (tie) -> best_angle_out=0, best_energy_out=200.
5. Sweep where angle 2 measure window is all -8388608 and all other samples are 0 -> best_energy_out=33554432, best_angle_out=2.
6. Reset and busy handling:
   - Assert start_in again during the angle-4 measure -> ignored; the sweep continues.
   - Assert rst_in during the angle-7 measure -> next cycle state IDLE, angle_out=8, delays=0, busy_out=0, no sweep_done_out.

Source files
------------

// File: rtl/beam_sweep_controller.sv
// Beam steering controller: drives per-mic delays and runs an energy-maximising sweep.
// The sweep settles, measures, and compares at each angle, then locks onto the loudest one.
module beam_sweep_controller #(
  parameter int NUM_MICS       = 4,
  parameter int BITS_AUDIO     = 24,
  parameter int NUM_ANGLES     = 16,
  parameter int DELAY_STEP     = 2,
  parameter int SETTLE_SAMPLES = 8,
  parameter int DWELL_SAMPLES  = 256,
  localparam int AW = $clog2(NUM_ANGLES),
  localparam int EW = BITS_AUDIO + $clog2(DWELL_SAMPLES)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         manual_en_in,
  input  logic [AW-1:0]                manual_angle_in,
  input  logic signed [BITS_AUDIO-1:0] audio_in,
  input  logic                         audio_valid_in,
  output logic [7:0]                   delay_1,
  output logic [7:0]                   delay_2,
  output logic [7:0]                   delay_3,
  output logic [7:0]                   delay_4,
  output logic [AW-1:0]                angle_out,
  output logic [AW-1:0]                best_angle_out,
  output logic [EW-1:0]                best_energy_out,
  output logic                         busy_out,
  output logic                         sweep_done_out
);

  localparam int CNT_MAX = (SETTLE_SAMPLES > DWELL_SAMPLES) ? SETTLE_SAMPLES : DWELL_SAMPLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [AW-1:0] BROADSIDE   = AW'(NUM_ANGLES / 2);
  localparam logic [AW-1:0] LAST_ANGLE  = AW'(NUM_ANGLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_SAMPLES - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   angle_q, angle_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   best_angle_q, best_angle_d;
  logic [EW-1:0]   best_energy_q, best_energy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0][7:0] delay_q, delay_d;

  // Two's-complement negation read as unsigned keeps |-2^(B-1)| = 2^(B-1).
  logic [BITS_AUDIO-1:0] audio_mag;
  assign audio_mag = audio_in[BITS_AUDIO-1] ? ($unsigned(~audio_in) + BITS_AUDIO'(1))
                                            : $unsigned(audio_in);

  logic signed [AW:0] steer;
  logic                steer_neg;
  logic [AW:0]         steer_mag;
  assign steer     = $signed({1'b0, angle_q}) - $signed({1'b0, BROADSIDE});
  assign steer_neg = steer[AW];
  assign steer_mag = steer_neg ? $unsigned(-steer) : $unsigned(steer);

  // Positive steer delays mics from the first one outward; negative steer mirrors that.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_delay
      if (gi < NUM_MICS) begin : g_active
        localparam int WPOS = gi;
        localparam int WNEG = NUM_MICS - 1 - gi;
        logic [31:0] prod;
        assign prod = 32'(steer_mag) * (steer_neg ? 32'(WNEG) : 32'(WPOS)) * 32'(DELAY_STEP);
        assign delay_d[gi] = (prod > 32'd255) ? 8'hFF : prod[7:0];
      end else begin : g_unused
        assign delay_d[gi] = 8'd0;
      end
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      angle_q       <= BROADSIDE;
      cnt_q         <= '0;
      acc_q         <= '0;
      best_angle_q  <= BROADSIDE;
      best_energy_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      delay_q       <= '0;
    end else begin
      state_q       <= state_d;
      angle_q       <= angle_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      best_angle_q  <= best_angle_d;
      best_energy_q <= best_energy_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      delay_q       <= delay_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_in) state_d = S_SETTLE;
      S_SETTLE:  if (audio_valid_in && cnt_q == SETTLE_LAST) state_d = S_MEASURE;
      S_MEASURE: if (audio_valid_in && cnt_q == DWELL_LAST) state_d = S_COMPARE;
      S_COMPARE: state_d = (angle_q == LAST_ANGLE) ? S_DONE : S_SETTLE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    angle_d       = angle_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    best_angle_d  = best_angle_q;
    best_energy_d = best_energy_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          angle_d       = '0;
          best_energy_d = '0;
          best_angle_d  = BROADSIDE;
          cnt_d         = '0;
          busy_d        = 1'b1;
        end else if (manual_en_in) begin
          angle_d = manual_angle_in;
        end
      end
      S_SETTLE: begin
        if (audio_valid_in) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d = '0;
            acc_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_MEASURE: begin
        if (audio_valid_in) begin
          acc_d = acc_q + EW'(audio_mag);
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_COMPARE: begin
        // Strict compare so a tie keeps the earlier angle.
        if (acc_q > best_energy_q) begin
          best_energy_d = acc_q;
          best_angle_d  = angle_q;
        end
        if (angle_q != LAST_ANGLE) begin
          angle_d = angle_q + AW'(1);
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        angle_d = best_angle_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign delay_1         = delay_q[0];
  assign delay_2         = delay_q[1];
  assign delay_3         = delay_q[2];
  assign delay_4         = delay_q[3];
  assign angle_out       = angle_q;
  assign best_angle_out  = best_angle_q;
  assign best_energy_out = best_energy_q;
  assign busy_out        = busy_q;
  assign sweep_done_out  = done_q;

endmodule

// File: tb/tb_beam_sweep_controller.sv
// Directed bench for beam_sweep_controller: reset, manual steering, three sweeps,
// start-while-busy and mid-sweep reset, checked through an expectation queue.
module tb_beam_sweep_controller;

  localparam int NUM_MICS       = 4;
  localparam int BITS_AUDIO     = 24;
  localparam int NUM_ANGLES     = 16;
  localparam int DELAY_STEP     = 2;
  localparam int SETTLE_SAMPLES = 2;
  localparam int DWELL_SAMPLES  = 4;
  localparam int AW = $clog2(NUM_ANGLES);
  localparam int EW = BITS_AUDIO + $clog2(DWELL_SAMPLES);

  logic                         clk;
  logic                         rst_in;
  logic                         start_in;
  logic                         manual_en_in;
  logic [AW-1:0]                manual_angle_in;
  logic signed [BITS_AUDIO-1:0] audio_in;
  logic                         audio_valid_in;
  logic [7:0]                   delay_1, delay_2, delay_3, delay_4;
  logic [AW-1:0]                angle_out, best_angle_out;
  logic [EW-1:0]                best_energy_out;
  logic                         busy_out, sweep_done_out;

  beam_sweep_controller #(
    .NUM_MICS(NUM_MICS), .BITS_AUDIO(BITS_AUDIO), .NUM_ANGLES(NUM_ANGLES),
    .DELAY_STEP(DELAY_STEP), .SETTLE_SAMPLES(SETTLE_SAMPLES), .DWELL_SAMPLES(DWELL_SAMPLES)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .manual_en_in(manual_en_in),
    .manual_angle_in(manual_angle_in), .audio_in(audio_in), .audio_valid_in(audio_valid_in),
    .delay_1(delay_1), .delay_2(delay_2), .delay_3(delay_3), .delay_4(delay_4),
    .angle_out(angle_out), .best_angle_out(best_angle_out), .best_energy_out(best_energy_out),
    .busy_out(busy_out), .sweep_done_out(sweep_done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int mode = 0;
  int vidx = 0;

  task automatic push_exp(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic push_delays(input int a, input int b, input int c, input int d);
    push_exp("delay_1", 64'(a));
    push_exp("delay_2", 64'(b));
    push_exp("delay_3", 64'(c));
    push_exp("delay_4", 64'(d));
  endtask

  task automatic pop_delays();
    pop_chk(64'(delay_1));
    pop_chk(64'(delay_2));
    pop_chk(64'(delay_3));
    pop_chk(64'(delay_4));
  endtask

  // Advance one clock, sample just after the edge, then drive audio for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sweep_done_out === 1'b1) done_cnt++;
    audio_valid_in = (mode != 0) && (cyc % 4 == 0);
    audio_in = '0;
    if (audio_valid_in) begin
      case (mode)
        1: begin
          audio_in = (angle_out == 3) ? 24'sd100 : 24'sd10;
          if (vidx[0]) audio_in = -audio_in;
        end
        2: audio_in = 24'sd50;
        3: audio_in = (angle_out == 2) ? 24'sh800000 : 24'sd0;
        default: ;
      endcase
      vidx++;
    end
  endtask

  task automatic start_sweep();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sweep_done_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (sweep_done_out !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sweep_timeout observed=no_done expected=done_within_%0d", budget);
    end
  endtask

  task automatic wait_angle(input int target, input int budget);
    int n = 0;
    while (angle_out !== AW'(target) && n < budget) begin
      tick();
      n++;
    end
    if (angle_out !== AW'(target)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL angle_timeout observed=%0d expected=%0d", angle_out, target);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    start_in = 1'b0;
    manual_en_in = 1'b0;
    manual_angle_in = '0;
    audio_in = '0;
    audio_valid_in = 1'b0;

    // Reset state
    tick();
    tick();
    push_delays(0, 0, 0, 0);
    push_exp("rst_angle", 8);
    push_exp("rst_best_angle", 8);
    push_exp("rst_best_energy", 0);
    push_exp("rst_busy", 0);
    push_exp("rst_done", 0);
    pop_delays();
    pop_chk(64'(angle_out));
    pop_chk(64'(best_angle_out));
    pop_chk(64'(best_energy_out));
    pop_chk(64'(busy_out));
    pop_chk(64'(sweep_done_out));
    rst_in = 1'b0;

    // Manual steering; delays trail angle_out by one cycle
    manual_en_in = 1'b1;
    manual_angle_in = 11;
    push_exp("man11_angle", 11);
    tick();
    pop_chk(64'(angle_out));
    push_delays(0, 6, 12, 18);
    tick();
    pop_delays();

    manual_angle_in = 5;
    push_exp("man5_angle", 5);
    push_exp("man5_delay1_lag", 0);
    tick();
    pop_chk(64'(angle_out));
    pop_chk(64'(delay_1));
    push_delays(18, 12, 6, 0);
    tick();
    pop_delays();

    manual_angle_in = 0;
    push_delays(48, 32, 16, 0);
    tick();
    tick();
    pop_delays();

    manual_en_in = 1'b0;
    manual_angle_in = 13;
    push_exp("man_off_angle", 0);
    tick();
    tick();
    pop_chk(64'(angle_out));

    // Sweep with a loud angle 3
    mode = 1;
    done_cnt = 0;
    start_sweep();
    push_exp("sw1_busy", 1);
    push_exp("sw1_angle0", 0);
    pop_chk(64'(busy_out));
    pop_chk(64'(angle_out));
    wait_done(1500);
    push_exp("sw1_best_angle", 3);
    push_exp("sw1_best_energy", 400);
    push_exp("sw1_angle", 3);
    push_exp("sw1_busy_end", 0);
    pop_chk(64'(best_angle_out));
    pop_chk(64'(best_energy_out));
    pop_chk(64'(angle_out));
    pop_chk(64'(busy_out));
    tick();
    push_delays(30, 20, 10, 0);
    push_exp("sw1_done_width", 0);
    pop_delays();
    pop_chk(64'(sweep_done_out));
    repeat (5) tick();
    push_exp("sw1_done_count", 1);
    pop_chk(64'(done_cnt));

    // Tie sweep; start wins over a simultaneous manual request
    mode = 2;
    manual_en_in = 1'b1;
    manual_angle_in = 9;
    start_sweep();
    manual_en_in = 1'b0;
    push_exp("sw2_start_angle", 0);
    push_exp("sw2_start_energy", 0);
    push_exp("sw2_start_best_angle", 8);
    pop_chk(64'(angle_out));
    pop_chk(64'(best_energy_out));
    pop_chk(64'(best_angle_out));
    wait_done(1500);
    push_exp("sw2_best_angle", 0);
    push_exp("sw2_best_energy", 200);
    push_exp("sw2_angle", 0);
    pop_chk(64'(best_angle_out));
    pop_chk(64'(best_energy_out));
    pop_chk(64'(angle_out));
    tick();
    push_delays(48, 32, 16, 0);
    pop_delays();

    // Full-scale negative samples on angle 2 only
    mode = 3;
    start_sweep();
    wait_done(1500);
    push_exp("sw3_best_energy", 33554432);
    push_exp("sw3_best_angle", 2);
    push_exp("sw3_angle", 2);
    pop_chk(64'(best_energy_out));
    pop_chk(64'(best_angle_out));
    pop_chk(64'(angle_out));
    tick();
    push_delays(36, 24, 12, 0);
    pop_delays();

    // Start while busy is ignored, then reset mid-sweep
    mode = 1;
    done_cnt = 0;
    start_sweep();
    wait_angle(4, 600);
    repeat (12) tick();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    push_exp("busy_start_angle", 4);
    push_exp("busy_start_busy", 1);
    pop_chk(64'(angle_out));
    pop_chk(64'(busy_out));
    wait_angle(5, 200);
    push_exp("busy_continue_angle", 5);
    pop_chk(64'(angle_out));
    wait_angle(7, 400);
    repeat (12) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    push_exp("mid_rst_angle", 8);
    push_exp("mid_rst_busy", 0);
    push_exp("mid_rst_done", 0);
    push_exp("mid_rst_best_angle", 8);
    push_exp("mid_rst_best_energy", 0);
    push_delays(0, 0, 0, 0);
    pop_chk(64'(angle_out));
    pop_chk(64'(busy_out));
    pop_chk(64'(sweep_done_out));
    pop_chk(64'(best_angle_out));
    pop_chk(64'(best_energy_out));
    pop_delays();
    mode = 0;
    repeat (20) tick();
    push_exp("mid_rst_no_done", 0);
    push_exp("mid_rst_idle_angle", 8);
    pop_chk(64'(done_cnt));
    pop_chk(64'(angle_out));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
